// File: rtl/serial_to_parallel.sv
// Serial-to-parallel word assembler with a first-word-fall-through output FIFO.
// Bits arrive LSB first, qualified by valid_i. Each completed word is written
// to the FIFO tail on the edge that samples its last bit. A word completing
// while the FIFO is full (and no pop happens on that edge) is dropped, and a
// sticky overflow flag records the loss.
module serial_to_parallel #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       serial_i,
  input  logic                       valid_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           parallel_o,
  output logic                       rd_valid_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  // Bit counter width (at least one bit, even for WIDTH == 1).
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // FIFO pointer width (at least one bit).
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Occupancy counter width: must be able to hold DEPTH itself.
  localparam int CW  = $clog2(DEPTH) + 1;

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WIDTH - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]  EMPTY_CNT = CW'(0);

  // Registered state
  logic [BCW-1:0]   bit_cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;

  // Next-state and control signals
  logic [BCW-1:0]   bit_cnt_nxt_s;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [WIDTH-1:0] word_s;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_nxt_s;
  logic             overflow_nxt_s;
  logic             is_empty_s;
  logic             is_full_s;
  logic             complete_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;

  // Status flags come straight from the registered occupancy count, never
  // from pointer comparison, so they are always mutually consistent.
  assign is_empty_s = (count_r == EMPTY_CNT);
  assign is_full_s  = (count_r == FULL_CNT);

  // Word assembly: merge the current serial bit into its LSB-first position.
  always_comb begin
    word_s = shift_r;
    if (valid_i) begin
      word_s[bit_cnt_r] = serial_i;
    end else begin
      word_s = shift_r;
    end
  end

  // Transfer decisions for this edge: completion, pop, push and drop.
  always_comb begin
    complete_s = valid_i && (bit_cnt_r == LAST_BIT);
    pop_s      = pop_i && !is_empty_s;
    // A pop on the same edge frees the slot the completed word needs.
    push_s     = complete_s && (!is_full_s || pop_s);
    drop_s     = complete_s && is_full_s && !pop_s;
  end

  // Next bit counter and shift register; both hold while valid_i is low.
  always_comb begin
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    if (complete_s) begin
      bit_cnt_nxt_s = '0;
      shift_nxt_s   = '0;
    end else if (valid_i) begin
      bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
      shift_nxt_s   = word_s;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
      shift_nxt_s   = shift_r;
    end
  end

  // Next FIFO pointers; they wrap naturally modulo DEPTH (power of two).
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Next occupancy count and sticky overflow flag.
  always_comb begin
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r | drop_s;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Assembler and FIFO control state; async reset discards any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  // FIFO storage: completed word lands at the tail on its completion edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // First-word fall-through: head entry is visible without a read strobe,
  // and the output is forced to zero whenever nothing valid is held.
  always_comb begin
    parallel_o = '0;
    if (!is_empty_s) begin
      parallel_o = mem_r[rd_ptr_r];
    end else begin
      parallel_o = '0;
    end
  end

  assign rd_valid_o = !is_empty_s;
  assign empty_o    = is_empty_s;
  assign full_o     = is_full_s;
  assign count_o    = count_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: table-driven basic/gap words,
// hand-written overflow, full-plus-pop and reset sequences, then randomized
// traffic compared against a queue-based reference model.
module tb_serial_to_parallel;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset_n;
  logic             serial_i;
  logic             valid_i;
  logic             pop_i;
  logic [WIDTH-1:0] parallel_o;
  logic             rd_valid_o;
  logic             empty_o;
  logic             full_o;
  logic [2:0]       count_o;
  logic             overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: words held, partial word in progress, sticky flag.
  int q[$];
  int part;
  int nbits;
  bit ovf;

  typedef struct {
    logic       valid;
    logic       serial;
    logic       pop;
    logic [3:0] exp_par;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t tbl [13];

  serial_to_parallel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .serial_i  (serial_i),
    .valid_i   (valid_i),
    .pop_i     (pop_i),
    .parallel_o(parallel_o),
    .rd_valid_o(rd_valid_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    part  = 0;
    nbits = 0;
    ovf   = 1'b0;
  endtask

  // One edge of the reference model, from the behavioural rules.
  task automatic model_step(input bit v, input bit s, input bit p);
    bit full_before;
    bit popped;
    bit comp;
    int w;
    full_before = (q.size() == DEPTH);
    popped      = p && (q.size() > 0);
    comp        = 1'b0;
    w           = 0;
    if (v) begin
      part  = part | (int'(s) << nbits);
      nbits = nbits + 1;
      if (nbits == WIDTH) begin
        comp  = 1'b1;
        w     = part;
        part  = 0;
        nbits = 0;
      end
    end
    if (popped) void'(q.pop_front());
    if (comp) begin
      if (!full_before || popped) q.push_back(w);
      else ovf = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    int exp_par;
    exp_par = (q.size() > 0) ? q[0] : 0;
    check({tag, ".parallel"}, parallel_o, exp_par);
    check({tag, ".rd_valid"}, rd_valid_o, (q.size() > 0));
    check({tag, ".empty"},    empty_o,    (q.size() == 0));
    check({tag, ".full"},     full_o,     (q.size() == DEPTH));
    check({tag, ".count"},    count_o,    q.size());
    check({tag, ".overflow"}, overflow_o, ovf);
  endtask

  // Drive inputs for one cycle, advance model and DUT, settle past the edge.
  task automatic cycle(input bit v, input bit s, input bit p);
    valid_i  = v;
    serial_i = s;
    pop_i    = p;
    model_step(v, s, p);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int w, input bit pop_last);
    for (int i = 0; i < WIDTH; i++) begin
      cycle(1'b1, bit'((w >> i) & 1), pop_last && (i == WIDTH - 1));
    end
    valid_i = 1'b0;
    pop_i   = 1'b0;
  endtask

  // Reset asserted mid-cycle with junk inputs; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset_n  = 1'b0;
    valid_i  = 1'b1;
    serial_i = 1'b1;
    pop_i    = 1'b1;
    model_reset();
    #1;
    compare_all("reset_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all("reset_hold");
    reset_n  = 1'b1;
    valid_i  = 1'b0;
    serial_i = 1'b0;
    pop_i    = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    valid_i  = 1'b0;
    serial_i = 1'b0;
    pop_i    = 1'b0;
    model_reset();

    // Basic word 1,0,1,1 -> D, then pop; gapped word 0,1,(gap x3),1,0 -> 6, then pop.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'hD, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'h0, 3'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'h6, 3'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 4'h0, 3'd0};

    @(posedge clk);
    #1;
    compare_all("por");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    compare_all("por_release");

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].valid, tbl[i].serial, tbl[i].pop);
      check($sformatf("tbl%0d.parallel", i), parallel_o, tbl[i].exp_par);
      check($sformatf("tbl%0d.count", i), count_o, tbl[i].exp_cnt);
      check($sformatf("tbl%0d.rd_valid", i), rd_valid_o, (tbl[i].exp_cnt != 3'd0));
    end

    // Overflow: four words fill the FIFO, the fifth is dropped.
    for (int w = 1; w <= 4; w++) send_word(w, 1'b0);
    check("ovf.full", full_o, 1'b1);
    check("ovf.count4", count_o, 3'd4);
    check("ovf.not_yet", overflow_o, 1'b0);
    send_word(5, 1'b0);
    check("ovf.flag", overflow_o, 1'b1);
    check("ovf.count_kept", count_o, 3'd4);
    for (int w = 1; w <= 4; w++) begin
      check($sformatf("ovf.pop%0d", w), parallel_o, w);
      cycle(1'b0, 1'b0, 1'b1);
    end
    check("ovf.empty", empty_o, 1'b1);
    check("ovf.sticky", overflow_o, 1'b1);
    // Pop while empty changes nothing.
    cycle(1'b0, 1'b0, 1'b1);
    compare_all("pop_empty");
    check("pop_empty.count", count_o, 3'd0);

    // Leave a word in the FIFO so the mid-cycle reset clears visible state.
    send_word(9, 1'b0);
    do_reset();
    check("rst.overflow_cleared", overflow_o, 1'b0);

    // Full plus pop on the completion edge: no drop, count stays 4.
    for (int w = 1; w <= 4; w++) send_word(w, 1'b0);
    send_word(5, 1'b1);
    check("fp.overflow", overflow_o, 1'b0);
    check("fp.count", count_o, 3'd4);
    check("fp.full", full_o, 1'b1);
    for (int w = 2; w <= 5; w++) begin
      check($sformatf("fp.pop%0d", w), parallel_o, w);
      cycle(1'b0, 1'b0, 1'b1);
    end
    check("fp.empty", empty_o, 1'b1);

    // Completion plus pop at partial fill: count unchanged.
    send_word(7, 1'b0);
    send_word(8, 1'b1);
    check("mid.count", count_o, 3'd1);
    check("mid.head", parallel_o, 4'h8);
    cycle(1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial bits.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    send_word(15, 1'b0);
    check("rmw.parallel", parallel_o, 4'hF);
    check("rmw.count", count_o, 3'd1);
    cycle(1'b0, 1'b0, 1'b1);
    compare_all("rmw.after_pop");

    // Randomized traffic against the reference model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, bit'($urandom & 1), $urandom_range(0, 3) == 0);
      compare_all("rand");
      if ((i % 700) == 699) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter WIDTH, default 4: bits per assembled word.
REQ-002 Parameter DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-003 The block SHALL expose these ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- serial_i  input  1  serial data bit, LSB of each word first.
- valid_i  input  1  serial_i carries a valid bit this cycle.
- pop_i  input  1  consumer takes the head word this cycle.
- parallel_o  output  WIDTH  head word of FIFO; 0 when empty.
- rd_valid_o  output  1  parallel_o holds a valid word.
- empty_o  output  1  FIFO holds no words.
- full_o  output  1  FIFO holds DEPTH words.
- count_o  output  $clog2(DEPTH)+1  number of words held.
- overflow_o  output  1  sticky: a completed word was dropped.

Function
REQ-004 The block SHALL sit directly downstream of parallel_to_serial: serial_i and valid_i connect to its serial_o and valid_o.
REQ-005 Bit counter 0..WIDTH-1 and shift register SHALL advance only on cycles with valid_i=1; valid_i=0 holds both unchanged (gaps of any length allowed mid-word).
REQ-006 Bit k of a word (k = bit counter value at sampling) SHALL land in position k of the assembled word (LSB-first).
REQ-007 On the edge that samples bit WIDTH-1, the assembled word SHALL be written to FIFO tail on that same edge and the bit counter SHALL wrap to 0.
REQ-008 Latency: word visible on parallel_o with rd_valid_o=1 in the cycle after its last bit was sampled, if the FIFO was empty.
REQ-009 parallel_o SHALL be combinational from the head entry (first-word fall-through); rd_valid_o = ~empty_o.
REQ-010 pop_i with rd_valid_o=1 SHALL remove the head on that edge; pop_i when empty SHALL be ignored with no state change.
REQ-011 Word completion while full and no pop: word SHALL be dropped, FIFO contents and order unchanged, overflow_o set to 1 on that edge.
REQ-012 Word completion and pop on the same edge while full: both SHALL take effect, no drop, overflow_o unchanged, count_o stays DEPTH.
REQ-013 Completion and pop on the same edge at any other fill level: count_o SHALL be unchanged.
REQ-014 overflow_o SHALL stay 1 until reset; no other clear path.
REQ-015 Read/write pointers SHALL wrap modulo DEPTH; full/empty derived from count, never from pointer equality alone.
REQ-016 count_o, empty_o and full_o SHALL be registered-state-derived and consistent on every cycle: empty_o=(count_o==0), full_o=(count_o==DEPTH).

Reset
REQ-017 reset_n=0 SHALL asynchronously clear bit counter, shift register, pointers, count and overflow_o, without waiting for a clock edge.
REQ-018 During and after reset: parallel_o=0, rd_valid_o=0, empty_o=1, full_o=0, count_o=0, overflow_o=0.
REQ-019 A partially assembled word at reset assertion SHALL be discarded; the first valid bit after release is bit 0 of a new word.
REQ-020 Inputs SHALL be ignored while reset_n=0; release is synchronised by the integrator, not internally.

Verification
REQ-021 Reset: assert reset_n=0 mid-cycle -> all outputs take REQ-018 values immediately, before the next edge.
REQ-022 Basic word: serial_i=1,0,1,1 on four consecutive valid_i=1 cycles -> next cycle parallel_o=4'hD, rd_valid_o=1, count_o=1.
REQ-023 Gaps: bits 0,1 valid, valid_i=0 for 3 cycles with serial_i toggling, bits 1,0 valid -> parallel_o=4'h6, exactly one word.
REQ-024 Overflow: push words 1,2,3,4 with pop_i=0 -> full_o=1; fifth word 5 -> overflow_o=1, count_o=4, pops return 1,2,3,4 then empty_o=1.
REQ-025 Full plus pop: FIFO full with 1,2,3,4, word 5 completes on the edge pop_i=1 -> overflow_o=0, count_o=4, pops return 2,3,4,5.
REQ-026 Reset mid-word: two bits sampled, reset_n pulsed low, then bits 1,1,1,1 -> single word parallel_o=4'hF.
